// File: rtl/mnist_frame_binarizer_if.sv
// Handshake bundle of the MNIST frame binarizer: the raster pixel stream coming in
// and the pooled 49-bit vector going out.
interface mnist_frame_binarizer_if #(
  parameter int PIX_W = 8,
  parameter int OUT_W = 49
);
  logic             pix_valid;
  logic             pix_ready;
  logic [PIX_W-1:0] pix_data;
  logic             pix_last;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_bits;
  logic             frame_err;

  modport master (
    output pix_valid, pix_data, pix_last, out_ready,
    input  pix_ready, out_valid, out_bits, frame_err
  );

  modport slave (
    input  pix_valid, pix_data, pix_last, out_ready,
    output pix_ready, out_valid, out_bits, frame_err
  );
endinterface

// File: rtl/mnist_frame_binarizer.sv
// Pools a raster-order greyscale frame into one bit per BLKxBLK block and holds the
// finished vector in a single valid/ready output buffer for the gate-network classifier.
module mnist_frame_binarizer #(
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28,
  parameter int BLK        = 4,
  parameter int PIX_W      = 8,
  parameter int PIX_THRESH = 128,
  parameter int MIN_COUNT  = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  mnist_frame_binarizer_if.slave bus
);
  localparam int BW    = IMG_W / BLK;
  localparam int BH    = IMG_H / BLK;
  localparam int OUT_W = BW * BH;
  localparam int AW    = $clog2(BLK * BLK + 1);
  localparam int SW    = (BLK > 1) ? $clog2(BLK) : 1;
  localparam int CW    = (BW > 1) ? $clog2(BW) : 1;
  localparam int RW    = (BH > 1) ? $clog2(BH) : 1;
  localparam int VW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  // The column/row position is split into block index and offset within the block,
  // so col/BLK and row%BLK never need a divider.
  logic [SW-1:0]    sub_col_q, sub_col_d;
  logic [SW-1:0]    sub_row_q, sub_row_d;
  logic [CW-1:0]    blk_col_q, blk_col_d;
  logic [RW-1:0]    blk_row_q, blk_row_d;
  logic [AW-1:0]    acc_q [BW];
  logic [AW-1:0]    acc_d [BW];
  logic [OUT_W-1:0] vec_q, vec_d;
  logic [OUT_W-1:0] out_bits_q, out_bits_d;
  logic             out_valid_q, out_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             alive_q, alive_d;

  logic             pix_ready;
  logic             accept;
  logic             on_bit;
  logic             col_end;
  logic             row_end;
  logic             final_pos;
  logic             blk_end;
  logic [AW-1:0]    acc_sum;
  logic [VW-1:0]    bit_idx;
  logic [OUT_W-1:0] vec_next;

  // alive_q keeps the input stalled while reset is held and opens it one edge later.
  assign pix_ready     = alive_q & (~out_valid_q | bus.out_ready);
  assign bus.pix_ready = pix_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bits  = out_bits_q;
  assign bus.frame_err = frame_err_q;

  always_comb begin
    accept    = bus.pix_valid & pix_ready;
    on_bit    = bus.pix_data >= PIX_W'(PIX_THRESH);
    col_end   = (sub_col_q == SW'(BLK - 1)) && (blk_col_q == CW'(BW - 1));
    row_end   = (sub_row_q == SW'(BLK - 1)) && (blk_row_q == RW'(BH - 1));
    final_pos = col_end & row_end;
    blk_end   = (sub_row_q == SW'(BLK - 1)) && (sub_col_q == SW'(BLK - 1));
    acc_sum   = acc_q[blk_col_q] + AW'(on_bit);
    bit_idx   = VW'(blk_row_q) * VW'(BW) + VW'(blk_col_q);
    vec_next  = vec_q;
    if (blk_end) begin
      vec_next[bit_idx] = acc_sum >= AW'(MIN_COUNT);
    end

    sub_col_d   = sub_col_q;
    sub_row_d   = sub_row_q;
    blk_col_d   = blk_col_q;
    blk_row_d   = blk_row_q;
    acc_d       = acc_q;
    vec_d       = vec_q;
    out_bits_d  = out_bits_q;
    out_valid_d = out_valid_q & ~bus.out_ready;
    frame_err_d = 1'b0;
    alive_d     = 1'b1;

    if (accept) begin
      if (bus.pix_last && !final_pos) begin
        // Early end of frame: drop everything gathered so far and restart at pixel 0.
        frame_err_d = 1'b1;
        sub_col_d   = '0;
        sub_row_d   = '0;
        blk_col_d   = '0;
        blk_row_d   = '0;
        acc_d       = '{default: '0};
        vec_d       = '0;
      end else begin
        if (sub_col_q == SW'(BLK - 1)) begin
          sub_col_d = '0;
          if (blk_col_q == CW'(BW - 1)) begin
            blk_col_d = '0;
            if (sub_row_q == SW'(BLK - 1)) begin
              sub_row_d = '0;
              blk_row_d = row_end ? '0 : blk_row_q + RW'(1);
            end else begin
              sub_row_d = sub_row_q + SW'(1);
            end
          end else begin
            blk_col_d = blk_col_q + CW'(1);
          end
        end else begin
          sub_col_d = sub_col_q + SW'(1);
        end

        acc_d[blk_col_q] = blk_end ? '0 : acc_sum;
        vec_d            = vec_next;

        if (final_pos) begin
          out_bits_d  = vec_next;
          out_valid_d = 1'b1;
          vec_d       = '0;
          frame_err_d = ~bus.pix_last;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_col_q   <= '0;
      sub_row_q   <= '0;
      blk_col_q   <= '0;
      blk_row_q   <= '0;
      acc_q       <= '{default: '0};
      vec_q       <= '0;
      out_bits_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      sub_col_q   <= sub_col_d;
      sub_row_q   <= sub_row_d;
      blk_col_q   <= blk_col_d;
      blk_row_q   <= blk_row_d;
      acc_q       <= acc_d;
      vec_q       <= vec_d;
      out_bits_q  <= out_bits_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      alive_q     <= alive_d;
    end
  end
endmodule

// File: tb/tb_mnist_frame_binarizer.sv
// Directed bench for mnist_frame_binarizer: frames are built in an image array, their
// expected vectors queued from a block-count model and compared at each output handshake.
module tb_mnist_frame_binarizer;
  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int BLK   = 4;
  localparam int BW    = IMG_W / BLK;
  localparam int BH    = IMG_H / BLK;
  localparam int OUT_W = BW * BH;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam logic [OUT_W-1:0] ALL_ONES = {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0] DIAG     = 49'h1_0101_0101_0101;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mnist_frame_binarizer_if #(.PIX_W(8), .OUT_W(OUT_W)) bus ();

  mnist_frame_binarizer #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .BLK(BLK), .PIX_W(8), .PIX_THRESH(128), .MIN_COUNT(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0]       img [NPIX];
  logic [OUT_W-1:0] exp_q [$];
  logic [OUT_W-1:0] mon_exp;
  int checks     = 0;
  int errors     = 0;
  int err_pulses = 0;
  int outs_seen  = 0;
  int err_base   = 0;
  int out_base   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Scoreboard: every accepted output vector is matched against the oldest queued frame.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checkOutput("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          checkOutput("out_bits", 64'(bus.out_bits), 64'(mon_exp));
        end
        outs_seen++;
      end
      if (bus.frame_err === 1'b1) err_pulses++;
    end
  end

  function automatic logic [OUT_W-1:0] model_expected();
    logic [OUT_W-1:0] v;
    int cnt;
    v = '0;
    for (int br = 0; br < BH; br++) begin
      for (int bc = 0; bc < BW; bc++) begin
        cnt = 0;
        for (int y = 0; y < BLK; y++)
          for (int x = 0; x < BLK; x++)
            if (img[(br * BLK + y) * IMG_W + bc * BLK + x] >= 8'd128) cnt++;
        v[br * BW + bc] = (cnt >= 8);
      end
    end
    return v;
  endfunction

  task automatic fill_all(input logic [7:0] v);
    for (int i = 0; i < NPIX; i++) img[i] = v;
  endtask

  task automatic set_block_n(input int br, input int bc, input int n, input logic [7:0] v);
    for (int k = 0; k < n; k++)
      img[(br * BLK + k / BLK) * IMG_W + bc * BLK + k % BLK] = v;
  endtask

  // Sends pixels 0..n_pix-1 of img; pix_last marks index last_idx (-1 for none).
  task automatic applyStimulus(input int n_pix, input int last_idx, input bit gaps);
    int guard;
    err_base = err_pulses;
    out_base = outs_seen;
    for (int i = 0; i < n_pix; i++) begin
      if (gaps && $urandom_range(0, 5) == 0) begin
        bus.pix_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.pix_valid = 1'b1;
      bus.pix_data  = img[i];
      bus.pix_last  = (i == last_idx);
      @(negedge clk);
      guard = 0;
      while (bus.pix_ready !== 1'b1 && guard < 1000) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 1000) begin
        checkOutput("pix_ready_wait", 64'(bus.pix_ready), 64'd1);
        bus.pix_valid = 1'b0;
        return;
      end
      if (i == NPIX - 1) checkOutput("pre_last_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk); #1;
      bus.pix_valid = 1'b0;
      bus.pix_last  = 1'b0;
      if (i == NPIX - 1) begin
        @(negedge clk);
        checkOutput("latency_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic frameCheck(input string tag, input int exp_err, input int exp_outs);
    repeat (3) @(posedge clk);
    #1;
    checkOutput({tag, "_err_pulses"}, 64'(err_pulses - err_base), 64'(exp_err));
    checkOutput({tag, "_outputs"}, 64'(outs_seen - out_base), 64'(exp_outs));
    checkOutput({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.pix_last  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset state");
    checkOutput("rst_pix_ready", 64'(bus.pix_ready), 64'd0);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_out_bits", 64'(bus.out_bits), 64'd0);
    checkOutput("rst_frame_err", 64'(bus.frame_err), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("ready_after_release", 64'(bus.pix_ready), 64'd1);

    $display("[TB] uniform frames and threshold boundary");
    fill_all(8'h00); exp_q.push_back('0);
    applyStimulus(NPIX, NPIX - 1, 0); frameCheck("zero", 0, 1);
    fill_all(8'hFF); exp_q.push_back(ALL_ONES);
    applyStimulus(NPIX, NPIX - 1, 1); frameCheck("ff", 0, 1);
    fill_all(8'd127); exp_q.push_back('0);
    applyStimulus(NPIX, NPIX - 1, 0); frameCheck("p127", 0, 1);
    fill_all(8'd128); exp_q.push_back(ALL_ONES);
    applyStimulus(NPIX, NPIX - 1, 1); frameCheck("p128", 0, 1);

    $display("[TB] MIN_COUNT boundary in block r2 c5");
    fill_all(8'h00); set_block_n(2, 5, 8, 8'd200); exp_q.push_back(49'd1 << 19);
    applyStimulus(NPIX, NPIX - 1, 1); frameCheck("blk8", 0, 1);
    fill_all(8'h00); set_block_n(2, 5, 7, 8'd200); exp_q.push_back('0);
    applyStimulus(NPIX, NPIX - 1, 0); frameCheck("blk7", 0, 1);

    $display("[TB] random frame");
    for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
    exp_q.push_back(model_expected());
    applyStimulus(NPIX, NPIX - 1, 1); frameCheck("random", 0, 1);

    $display("[TB] output back-pressure");
    bus.out_ready = 1'b0;
    fill_all(8'hFF); exp_q.push_back(ALL_ONES);
    applyStimulus(NPIX, NPIX - 1, 0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput("stall_pix_ready", 64'(bus.pix_ready), 64'd0);
      checkOutput("stall_out_bits", 64'(bus.out_bits), 64'(ALL_ONES));
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("drain_valid_drop", 64'(bus.out_valid), 64'd0);
    frameCheck("stall", 0, 1);
    fill_all(8'h00); set_block_n(0, 0, 16, 8'hFF); exp_q.push_back(49'd1);
    applyStimulus(NPIX, NPIX - 1, 1); frameCheck("after_stall", 0, 1);

    $display("[TB] framing errors");
    fill_all(8'hFF);
    applyStimulus(101, 100, 0); frameCheck("early_last", 1, 0);
    checkOutput("early_last_valid", 64'(bus.out_valid), 64'd0);
    fill_all(8'h00);
    for (int k = 0; k < BW; k++) set_block_n(k, k, 16, 8'hFF);
    exp_q.push_back(DIAG);
    applyStimulus(NPIX, NPIX - 1, 1); frameCheck("diag", 0, 1);
    fill_all(8'h00); set_block_n(4, 2, 12, 8'hC0); exp_q.push_back(model_expected());
    applyStimulus(NPIX, -1, 0); frameCheck("missing_last", 1, 1);

    $display("[TB] asynchronous reset");
    bus.out_ready = 1'b0;
    fill_all(8'h00); set_block_n(3, 3, 16, 8'hFF);
    applyStimulus(NPIX, NPIX - 1, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("areset_out_bits", 64'(bus.out_bits), 64'd0);
    checkOutput("areset_pix_ready", 64'(bus.pix_ready), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    fill_all(8'hFF);
    applyStimulus(400, -1, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midframe_out_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fill_all(8'h00); set_block_n(0, 0, 16, 8'hFF); set_block_n(6, 6, 16, 8'hFF);
    exp_q.push_back(model_expected());
    applyStimulus(NPIX, NPIX - 1, 1); frameCheck("post_reset", 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    errors++;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
